// File: rtl/add_arbiter.sv
// add_arbiter: round-robin arbiter sharing one 32-bit carry-lookahead adder
// among NUM_REQ requesters, with a single-entry result register.
// Optional per-requester grant counters are built only when the macro
// ADD_ARB_STATS_EN is defined; otherwise grant_cnt is tied to zero.

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
// resolved from group generate/propagate terms.
module add_cla (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [31:0] p;
    logic [31:0] g;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] c_in;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // group generate / propagate for each 4-bit slice
    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 8; k++) begin
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p[k] = &p[4*k +: 4];
        end
    end

    // carry into each group; a local running term avoids a self-referencing vector
    always_comb begin
        logic carry_run;
        carry_run = 1'b0;
        grp_c     = '0;
        for (int k = 0; k < 8; k++) begin
            grp_c[k]  = carry_run;
            carry_run = grp_g[k] | (grp_p[k] & carry_run);
        end
        grp_c[8] = carry_run;
    end

    // per-bit carries inside each group, looked ahead from the group carry-in
    always_comb begin
        c_in = '0;
        for (int k = 0; k < 8; k++) begin
            c_in[4*k]   = grp_c[k];
            c_in[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
            c_in[4*k+2] = g[4*k+1]
                        | (p[4*k+1] & g[4*k])
                        | (p[4*k+1] & p[4*k] & grp_c[k]);
            c_in[4*k+3] = g[4*k+2]
                        | (p[4*k+2] & g[4*k+1])
                        | (p[4*k+2] & p[4*k+1] & g[4*k])
                        | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    assign sum_o  = p ^ c_in;
    assign cout_o = grp_c[8];
endmodule

module add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*32-1:0]        req_a,
    input  logic [NUM_REQ*32-1:0]        req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [31:0]                  resp_sum,
    output logic                         resp_carry,
    output logic [NUM_REQ*CNT_W-1:0]     grant_cnt
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [31:0]        resp_sum_q, resp_sum_d;
    logic               resp_carry_q, resp_carry_d;

    logic               accept;
    logic               hi_vld, lo_vld;
    logic [ID_W-1:0]    hi_idx, lo_idx;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic               handshake;
    logic [31:0]        op_a, op_b;
    logic [31:0]        add_sum;
    logic               add_cout;

    // result register is a one-deep stage: refill whenever empty or draining
    assign accept = !resp_valid_q || resp_ready;

    // round-robin: first valid above ptr, else first valid at or below ptr
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hi_vld && req_valid[i] && (ID_W'(i) > ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = ID_W'(i);
            end
            if (!lo_vld && req_valid[i] && (ID_W'(i) <= ptr_q)) begin
                lo_vld = 1'b1;
                lo_idx = ID_W'(i);
            end
        end
        grant_vld = hi_vld || lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    assign handshake = grant_vld && accept && !rst;

    // one-hot ready, only when a handshake actually happens this cycle
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = handshake && (grant_idx == ID_W'(i));
        end
    end

    assign req_ready = grant_oh;

    // operand mux feeding the shared adder
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                op_a = req_a[i*32 +: 32];
                op_b = req_b[i*32 +: 32];
            end
        end
    end

    add_cla u_add (
        .a_i    (op_a),
        .b_i    (op_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // next state: load on handshake, drain when consumed, otherwise hold
    always_comb begin
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_carry_d = resp_carry_q;
        if (handshake) begin
            ptr_d        = grant_idx;
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_sum_d   = add_sum;
            resp_carry_d = add_cout;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // state registers; reset leaves ptr at the last index so requester 0 goes first
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_carry_q <= resp_carry_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_carry = resp_carry_q;

`ifdef ADD_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    // saturating grant counters, one per requester
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_oh[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter (NUM_REQ=4, CNT_W=2). Expected results
// are pushed on handshake and popped when the result register updates.
module tb_add_arbiter;
    localparam int NR = 4;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*32-1:0] req_a;
    logic [NR*32-1:0] req_b;
    logic [NR-1:0]    req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [31:0]      resp_sum;
    logic             resp_carry;
    logic [NR*CW-1:0] grant_cnt;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        carry;
    } res_t;

    res_t sb_q[$];
    res_t held;
    int   n_checks = 0;
    int   n_fail   = 0;

    add_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_carry (resp_carry),
        .grant_cnt  (grant_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock with inputs already driven at the falling edge. exp_g is the
    // requester expected to be granted this cycle, or -1 for no grant.
    task automatic tick(input int exp_g);
        logic [NR-1:0] exp_rdy;
        logic [31:0]   la, lb;
        logic [32:0]   full;
        logic          rv_pre, rr_pre;
        res_t          e, got;
        #1;
        exp_rdy = (exp_g >= 0) ? NR'(1 << exp_g) : '0;
        n_checks++;
        if (req_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
        end
        if (exp_g >= 0) begin
            la    = 32'(req_a >> (exp_g * 32));
            lb    = 32'(req_b >> (exp_g * 32));
            full  = {1'b0, la} + {1'b0, lb};
            e.id    = 2'(exp_g);
            e.sum   = full[31:0];
            e.carry = full[32];
            sb_q.push_back(e);
        end
        rv_pre = resp_valid;
        rr_pre = resp_ready;
        @(posedge clk);
        @(negedge clk);
        got = {resp_id, resp_sum, resp_carry};
        if (exp_g >= 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (resp_valid !== 1'b1 || got !== e) begin
                n_fail++;
                $display("FAIL result: got v=%b id=%0d sum=%h c=%b expected v=1 id=%0d sum=%h c=%b",
                         resp_valid, resp_id, resp_sum, resp_carry, e.id, e.sum, e.carry);
            end
            held = e;
        end else if (rr_pre || !rv_pre) begin
            n_checks++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drain: resp_valid got %b expected 0", resp_valid);
            end
        end else begin
            n_checks++;
            if (resp_valid !== 1'b1 || got !== held) begin
                n_fail++;
                $display("FAIL hold: got v=%b id=%0d sum=%h c=%b expected v=1 id=%0d sum=%h c=%b",
                         resp_valid, resp_id, resp_sum, resp_carry, held.id, held.sum, held.carry);
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        req_a      = {$urandom, $urandom, $urandom, $urandom};
        req_b      = {$urandom, $urandom, $urandom, $urandom};
        rst        = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_sum !== 32'h0 ||
            resp_carry !== 1'b0 || grant_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b id=%0d sum=%h c=%b cnt=%h expected all zero",
                     resp_valid, resp_id, resp_sum, resp_carry, grant_cnt);
        end
        rst       = 1'b0;
        req_valid = 4'h0;
        sb_q.delete();
    endtask

    task automatic test_carry();
        req_valid  = 4'b0001;
        req_a      = {96'h0, 32'hFFFF_FFFF};
        req_b      = {96'h0, 32'h0000_0001};
        resp_ready = 1'b1;
        tick(0);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_sum !== 32'h0 || resp_carry !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_out: got v=%b id=%0d sum=%h c=%b expected v=1 id=0 sum=00000000 c=1",
                     resp_valid, resp_id, resp_sum, resp_carry);
        end
        req_valid = 4'b0000;
        tick(-1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        resp_ready = 1'b1;
        req_valid  = 4'hF;
        for (int k = 0; k < 5; k++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            tick(k % 4);
            n_checks++;
            if (resp_id !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL rr_order: step %0d got id %0d expected %0d", k, resp_id, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        tick(1);
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            tick(-1);
            n_checks++;
            if (resp_id !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_id: got %0d expected 1", resp_id);
            end
        end
        resp_ready = 1'b1;
        tick(2);
        req_valid = 4'b0000;
        tick(-1);
    endtask

    task automatic test_lone();
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            tick(2);
            n_checks++;
            if (resp_id !== 2'd2 || resp_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL lone: step %0d got v=%b id=%0d expected v=1 id=2", k, resp_valid, resp_id);
            end
        end
        req_valid = 4'b1001;
        tick(3);
        tick(0);
        req_valid = 4'b0000;
        tick(-1);
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        req_a = {$urandom, $urandom, $urandom, $urandom};
        req_b = {$urandom, $urandom, $urandom, $urandom};
        tick(0);
        resp_ready = 1'b0;
        req_valid  = 4'b0000;
        tick(-1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || grant_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b cnt=%h expected v=0 cnt=0", resp_valid, grant_cnt);
        end
        rst = 1'b0;
        sb_q.delete();
        tick(-1);
        resp_ready = 1'b1;
        tick(-1);
    endtask

    task automatic test_stats();
        int cexp;
        apply_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            tick(1);
`ifdef ADD_ARB_STATS_EN
            cexp = (k > 3) ? 3 : k;
`else
            cexp = 0;
`endif
            n_checks++;
            if (grant_cnt !== {4'b0000, 2'(cexp), 2'b00}) begin
                n_fail++;
                $display("FAIL grant_cnt: after %0d grants got %h expected %h",
                         k, grant_cnt, {4'b0000, 2'(cexp), 2'b00});
            end
        end
        req_valid = 4'b0000;
        tick(-1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_carry();
        test_back_to_back();
        test_backpressure();
        test_lone();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, which sets the number of requesters sharing one adder (range 2..8).
REQ-002 The block SHALL have parameter CNT_W, default 16, which sets the width of each grant statistics counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: bit i is asserted when requester i presents an operand pair.
REQ-006 The block SHALL have port req_a, input, NUM_REQ*32 bits: operand A, with requester i at bits [32i+31:32i].
REQ-007 The block SHALL have port req_b, input, NUM_REQ*32 bits: operand B, packed the same way as req_a.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: one-hot or zero; bit i marks a handshake with requester i.
REQ-009 The block SHALL have port resp_valid, output, 1 bit: the result register holds a valid result.
REQ-010 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port resp_id, output, clog2(NUM_REQ) bits: index of the requester that owns the result.
REQ-012 The block SHALL have port resp_sum, output, 32 bits: (a+b) mod 2^32.
REQ-013 The block SHALL have port resp_carry, output, 1 bit: unsigned carry-out, computed as resp_sum < a.
REQ-014 The block SHALL have port grant_cnt, output, NUM_REQ*CNT_W bits: per-requester grant counters.

Function
REQ-015 The block SHALL compute the sum by instantiating exactly one Add carry-lookahead adder, fed from the mux selected by the granted requester.
REQ-016 The block SHALL set accept = !resp_valid | resp_ready, making the result register a single-entry pipeline stage.
REQ-017 The block SHALL, when accept is high, grant the first requester with req_valid set, searching round-robin from index ptr+1 and wrapping after NUM_REQ-1 back to 0.
REQ-018 The block SHALL drive req_ready combinationally as the grant bit AND accept, and SHALL hold req_ready at zero when no requester is valid or when accept is low.
REQ-019 The block SHALL, on a handshake with requester g in cycle N, load resp_sum, resp_carry and resp_id=g and set resp_valid in cycle N+1 (1-cycle latency).
REQ-020 The block SHALL update ptr to g only on a handshake; with no handshake, ptr SHALL hold.
REQ-021 The block SHALL, when resp_valid=1 and resp_ready=0, hold resp_valid, resp_id, resp_sum and resp_carry stable and issue no grants.
REQ-022 The block SHALL, when resp_ready=1 and a new handshake occur in the same cycle, replace the result in the following cycle with no bubble, giving throughput of 1 result per cycle.
REQ-023 The block SHALL, when resp_ready=1 with no new handshake, clear resp_valid in the next cycle.
REQ-024 The block SHALL serve a lone active requester every cycle; round-robin fairness SHALL NOT insert idle cycles.
REQ-025 The block SHALL NOT require requesters to hold req_valid; a withdrawn request is simply not granted.

Reset
REQ-026 The block SHALL, when rst=1 at a clock edge, clear resp_valid, resp_id, resp_sum, resp_carry and all grant counters to 0, and set ptr to NUM_REQ-1 so that requester 0 has first priority.
REQ-027 The block SHALL force req_ready to 0 while rst=1.
REQ-028 The block SHALL discard a result pending when reset asserts mid-operation; no response for it SHALL appear after reset.

Configuration
REQ-029 The block SHALL, with macro ADD_ARB_STATS_EN defined, increment grant counter i by 1 on each handshake with requester i, saturating at 2^CNT_W-1.
REQ-030 The block SHALL, without ADD_ARB_STATS_EN, keep the grant_cnt port with the same width, tie it to 0, and synthesize no counter logic.

Verification
REQ-031 The bench SHALL cover: reset, then req_valid=0001, a=0xFFFFFFFF, b=0x1, resp_ready=1 -> next cycle resp_valid=1, id=0, sum=0x0, carry=1.
REQ-032 The bench SHALL cover: all four requesters valid continuously, resp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-033 The bench SHALL cover: resp_valid=1 with resp_ready=0 for 3 cycles, requests pending -> req_ready=0, outputs stable for 3 cycles; the grant issues in the same cycle resp_ready rises.
REQ-034 The bench SHALL cover: only requester 2 valid for 5 cycles -> 5 consecutive results with id=2; ptr=2 afterwards, so requester 3 wins over 0 when both next assert.
REQ-035 The bench SHALL cover: rst asserted while resp_valid=1 and resp_ready=0 -> the next cycle shows resp_valid=0, grant_cnt=0 and the pending result lost.
REQ-036 The bench SHALL cover: with ADD_ARB_STATS_EN and CNT_W=2, 5 grants to requester 1 -> grant_cnt[1]=3 (saturated); without the macro, grant_cnt=0 always.
